hazard_unit_sb: RTL and testbench
=================================

// Module: hazard_unit_sb
// PURPOSE
//  Next-generation pipeline hazard controller for the RV32I core. It adds three things:
//   - a register scoreboard for multi-cycle ops (mul/div) that write back out of order;
//   - a configurable load-use bubble length;
//   - a data-cache busy freeze.
//  It also keeps EX operand forwarding (MEM over WB) and taken-branch flush. It sits beside the
//  datapath and drives all pipeline-register stall/flush enables and the EX forwarding muxes.
// PARAMETERS
//  NREG          32  architectural registers; RW = $clog2(NREG)
//  LOAD_BUBBLES  1   bubbles inserted per load-use hazard (1..4)
//  MAX_LONG      4   max outstanding long ops; CW = $clog2(MAX_LONG+1)
//  CNT_W         16  width of the saturating stall-cycle counter
// PORTS
//  clk            in   1      core clock
//  rst_n          in   1      asynchronous active-low reset
//  Rs1D,Rs2D,RdD  in   RW     ID source/dest registers
//  RegWriteD      in   1      ID instruction writes RdD
//  Rs1E,Rs2E,RdE  in   RW     EX source/dest registers
//  RegWriteE      in   1      EX instruction writes RdE
//  ResultSrcE_b0  in   1      EX instruction is a load
//  LongOpE        in   1      EX instruction is a multi-cycle op (mul/div)
//  PCSrcE         in   1      taken branch/jump in EX
//  RdM,RdW        in   RW     MEM/WB dests
//  RegWriteM/W    in   1      MEM/WB write enables; long ops always reach M with RegWriteM=0
//  LongDoneValid  in   1      long unit writes its result this cycle (2nd RF write port)
//  LongDoneRd     in   RW     dest of that completion
//  MemBusy        in   1      dcache not ready; whole pipe must hold
//  StallF/D/E/M   out  1      hold PC / IF-ID / ID-EX / EX-MEM
//  FlushD/E/M     out  1      bubble IF-ID / ID-EX / EX-MEM
//  ForwardAE/BE   out  2      fwd_sel_e: 00 RF, 01 WB, 10 MEM
//  StallCount     out  CNT_W  saturating count of cycles with StallF=1
// BEHAVIOUR
//  Reset: pend[]=0, outstanding=0, bubble_cnt=0, StallCount=0.
//  All outputs are combinational from state and inputs. During reset, all stall and flush
//  outputs are 0 and Forward*E=00.
//  Forwarding: only when Rs!=0.
//   - MEM match (RegWriteM, RdM!=0, Rs==RdM) selects 10.
//   - Else WB match selects 01.
//   - Else 00.
//   - Unknown (X) enables count as 0.
//  Load-use: ld_hit = ResultSrcE_b0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
//   - On ld_hit: StallF=StallD=FlushE=1, and bubble_cnt <= LOAD_BUBBLES-1.
//   - While bubble_cnt!=0: StallF=StallD=FlushE=1, and bubble_cnt decrements by 1 each cycle.
//  Scoreboard (RAW/WAW): sb_hit = pend[Rs1D] | pend[Rs2D] | (RegWriteD & pend[RdD]), with
//  register 0 never pending.
//   - A same-cycle LongDoneValid for that register suppresses the hit. The RF is write-first.
//   - sb_hit gives StallF=StallD=FlushE=1.
//  Long issue: LongOpE & RegWriteE & RdE!=0 & ~StallE sets pend[RdE] and increments outstanding.
//   - LongDoneValid clears pend[LongDoneRd] and decrements outstanding.
//   - If set and clear hit the same register in one cycle, set wins. outstanding is then net
//     unchanged.
//   - LongDoneValid with no pending bit is ignored.
//  Long full: LongOpE & outstanding==MAX_LONG & no completion this cycle.
//   - Gives StallF=StallD=StallE=1 and FlushM=1; the op holds in EX.
//  Branch: PCSrcE===1 gives FlushD=FlushE=1.
//   - Branch overrides load-use and scoreboard stalls: StallF/StallD=0 and bubble_cnt <= 0.
//   - A branch cannot coincide with long full, because EX holds a single instruction.
//  MemBusy=1:
//   - StallF/D/E/M=1, all flushes 0.
//   - bubble_cnt and pend-set freeze. Completions are still accepted.
//   - Branch, load-use and scoreboard effects are evaluated again once MemBusy drops.
//  StallCount increments on every cycle with StallF=1 and saturates at all-ones.
//  Asynchronous reset mid-operation drops all pending state immediately.
// STRUCTURE
//  hazard_pkg: fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}, and localparam
//  ZERO_REG=0.
//  Sub-module hazard_scoreboard (NREG, MAX_LONG):
//   - holds pend[] and outstanding;
//   - outputs sb_hit and long_full.
//  Top level holds forwarding, bubble counter, flush/stall priority and StallCount.
// TESTING
//  1. add x3 in M, sub uses x3 in EX -> ForwardAE=10. Same with x3 only in W -> 01.
//     Rs1E=x0 -> 00.
//  2. LOAD_BUBBLES=2; lw x5 in EX, add x6,x5 in ID -> StallF/D=1, FlushE=1 for exactly 2 cycles.
//     Forwarding then selects WB.
//  3. div x7 issues; next instr reads x7 -> StallD held until LongDoneValid/Rd=7.
//     The stall drops in that same cycle.
//  4. Issue 4 div ops (MAX_LONG=4) and a 5th in EX -> StallE=1, FlushM=1 until one completes.
//     outstanding never exceeds 4.
//  5. Load-use stall with PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0,
//     bubble_cnt cleared.
//  6. MemBusy for 3 cycles during a pending div, completion in cycle 2 -> pend cleared.
//     No flushes while busy. StallCount +3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32I hazard controller.
// The top level and the scoreboard import them.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for multi-cycle ops that write back out of order.
// It tracks one pend bit per register and the number of ops in flight.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned MAX_LONG = 4,
   localparam int unsigned RW      = $clog2(NREG),
   localparam int unsigned CW      = $clog2(MAX_LONG + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] rs1_d_i,
   input  logic [RW-1:0] rs2_d_i,
   input  logic [RW-1:0] rd_d_i,
   input  logic          reg_write_d_i,
   input  logic          long_op_e_i,
   input  logic          issue_i,
   input  logic [RW-1:0] issue_rd_i,
   input  logic          done_valid_i,
   input  logic [RW-1:0] done_rd_i,
   output logic          sb_hit_o,
   output logic          long_full_o
);

   logic [NREG-1:0] pend_q, pend_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic            done_eff;
   logic            hit_rs1, hit_rs2, hit_rd;

   // A completion only counts if its register is actually outstanding.
   assign done_eff = done_valid_i & pend_q[done_rd_i];

   // The RF is write-first, so a same-cycle completion already satisfies the reader.
   assign hit_rs1 = pend_q[rs1_d_i] & ~(done_valid_i & (done_rd_i == rs1_d_i));
   assign hit_rs2 = pend_q[rs2_d_i] & ~(done_valid_i & (done_rd_i == rs2_d_i));
   assign hit_rd  = pend_q[rd_d_i]  & ~(done_valid_i & (done_rd_i == rd_d_i));

   assign sb_hit_o    = hit_rs1 | hit_rs2 | (reg_write_d_i & hit_rd);
   assign long_full_o = long_op_e_i & (outstanding_q == CW'(MAX_LONG)) & ~done_eff;

   always_comb begin
      pend_d = pend_q;
      if (done_eff) begin
         pend_d[done_rd_i] = 1'b0;
      end
      // Set is applied last so it wins over a clear of the same register.
      if (issue_i) begin
         pend_d[issue_rd_i] = 1'b1;
      end
      pend_d[ZERO_REG] = 1'b0;
      outstanding_d = outstanding_q + CW'(issue_i) - CW'(done_eff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q        <= '0;
         outstanding_q <= '0;
      end else begin
         pend_q        <= pend_d;
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard controller: EX forwarding, load-use bubbles, long-op scoreboard,
// branch flush and dcache freeze, plus a saturating stall-cycle counter.
module hazard_unit_sb
   import hazard_pkg::*;
#(
   parameter int unsigned NREG         = 32,
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned MAX_LONG     = 4,
   parameter int unsigned CNT_W        = 16,
   localparam int unsigned RW          = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RW-1:0]    Rs1D,
   input  logic [RW-1:0]    Rs2D,
   input  logic [RW-1:0]    RdD,
   input  logic             RegWriteD,
   input  logic [RW-1:0]    Rs1E,
   input  logic [RW-1:0]    Rs2E,
   input  logic [RW-1:0]    RdE,
   input  logic             RegWriteE,
   input  logic             ResultSrcE_b0,
   input  logic             LongOpE,
   input  logic             PCSrcE,
   input  logic [RW-1:0]    RdM,
   input  logic [RW-1:0]    RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             LongDoneValid,
   input  logic [RW-1:0]    LongDoneRd,
   input  logic             MemBusy,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] StallCount
);

   logic [2:0]       bubble_q, bubble_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             sb_hit, long_full, ld_hit, branch, stall_req, issue;
   logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m;
   fwd_sel_e         fwd_a, fwd_b;

   function automatic fwd_sel_e fwd_mux(input logic [RW-1:0] rs, input logic [RW-1:0] rd_m,
                                        input logic [RW-1:0] rd_w, input logic we_m,
                                        input logic we_w);
      if (rs == RW'(ZERO_REG)) return FWD_RF;
      if ((we_m === 1'b1) && (rd_m != RW'(ZERO_REG)) && (rs == rd_m)) return FWD_MEM;
      if ((we_w === 1'b1) && (rd_w != RW'(ZERO_REG)) && (rs == rd_w)) return FWD_WB;
      return FWD_RF;
   endfunction

   assign fwd_a = fwd_mux(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
   assign fwd_b = fwd_mux(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

   assign ld_hit    = ResultSrcE_b0 & (RdE != RW'(ZERO_REG)) & ((Rs1D == RdE) | (Rs2D == RdE));
   assign branch    = (PCSrcE === 1'b1);
   assign stall_req = ld_hit | (bubble_q != 3'd0) | sb_hit;
   // StallE covers both the dcache freeze and a full long unit, so no issue happens then.
   assign issue     = LongOpE & RegWriteE & (RdE != RW'(ZERO_REG)) & ~stall_e;

   hazard_scoreboard #(
      .NREG    (NREG),
      .MAX_LONG(MAX_LONG)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .rs1_d_i      (Rs1D),
      .rs2_d_i      (Rs2D),
      .rd_d_i       (RdD),
      .reg_write_d_i(RegWriteD),
      .long_op_e_i  (LongOpE),
      .issue_i      (issue),
      .issue_rd_i   (RdE),
      .done_valid_i (LongDoneValid),
      .done_rd_i    (LongDoneRd),
      .sb_hit_o     (sb_hit),
      .long_full_o  (long_full)
   );

   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      bubble_d = 3'd0;
      if (MemBusy) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         stall_m  = 1'b1;
         bubble_d = bubble_q;
      end else if (branch) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else begin
         if (ld_hit) begin
            bubble_d = 3'(LOAD_BUBBLES - 1);
         end else if (bubble_q != 3'd0) begin
            bubble_d = bubble_q - 3'd1;
         end
         if (long_full) begin
            // The held op stays in EX, so EX is frozen rather than flushed.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (stall_req) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   assign StallF    = rst_n & stall_f;
   assign StallD    = rst_n & stall_d;
   assign StallE    = rst_n & stall_e;
   assign StallM    = rst_n & stall_m;
   assign FlushD    = rst_n & flush_d;
   assign FlushE    = rst_n & flush_e;
   assign FlushM    = rst_n & flush_m;
   assign ForwardAE = rst_n ? fwd_a : FWD_RF;
   assign ForwardBE = rst_n ? fwd_b : FWD_RF;
   assign StallCount = stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q    <= 3'd0;
         stall_cnt_q <= '0;
      end else begin
         bubble_q    <= bubble_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: stimulus queues expected outputs, a negedge monitor checks.
module tb_hazard_unit_sb;

   localparam int unsigned RW = 5;

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] LDST = 7'b1100010;
   localparam logic [6:0] FULL = 7'b1110001;
   localparam logic [6:0] BUSY = 7'b1111000;
   localparam logic [6:0] BRFL = 7'b0000110;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
   logic          RegWriteD, RegWriteE, ResultSrcE_b0, LongOpE, PCSrcE;
   logic          RegWriteM, RegWriteW, LongDoneValid, MemBusy;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [3:0]    StallCount;

   typedef struct {
      string       name;
      logic [10:0] bits;
      logic [3:0]  sc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       e;
   logic [10:0] act;
   logic [3:0] exp_sc;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   hazard_unit_sb #(
      .NREG        (32),
      .LOAD_BUBBLES(2),
      .MAX_LONG    (4),
      .CNT_W       (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Rs1D         (Rs1D),
      .Rs2D         (Rs2D),
      .RdD          (RdD),
      .RegWriteD    (RegWriteD),
      .Rs1E         (Rs1E),
      .Rs2E         (Rs2E),
      .RdE          (RdE),
      .RegWriteE    (RegWriteE),
      .ResultSrcE_b0(ResultSrcE_b0),
      .LongOpE      (LongOpE),
      .PCSrcE       (PCSrcE),
      .RdM          (RdM),
      .RdW          (RdW),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .LongDoneValid(LongDoneValid),
      .LongDoneRd   (LongDoneRd),
      .MemBusy      (MemBusy),
      .StallF       (StallF),
      .StallD       (StallD),
      .StallE       (StallE),
      .StallM       (StallM),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .FlushM       (FlushM),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .StallCount   (StallCount)
   );

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, ForwardAE, ForwardBE};
         n_checks++;
         if (act !== e.bits) begin
            n_errors++;
            $display("FAIL %s: stall/flush/fwd got %b want %b", e.name, act, e.bits);
         end
         n_checks++;
         if (StallCount !== e.sc) begin
            n_errors++;
            $display("FAIL %s: StallCount got %0d want %0d", e.name, StallCount, e.sc);
         end
      end
   end

   task automatic clr();
      Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0;
      Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteE = 1'b0;
      ResultSrcE_b0 = 1'b0; LongOpE = 1'b0; PCSrcE = 1'b0;
      RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      LongDoneValid = 1'b0; LongDoneRd = '0; MemBusy = 1'b0;
   endtask

   // Queue the expectation for the currently driven inputs, then advance one cycle.
   task automatic chk(input string nm, input logic [6:0] sfl, input logic [1:0] fa,
                      input logic [1:0] fb);
      exp_t x;
      x.name = nm;
      x.bits = {sfl, fa, fb};
      x.sc   = exp_sc;
      exp_q.push_back(x);
      if (sfl[6] && (exp_sc != 4'hF)) exp_sc = exp_sc + 4'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic long_op(input logic [RW-1:0] rd);
      clr(); LongOpE = 1'b1; RegWriteE = 1'b1; RdE = rd;
   endtask

   task automatic done(input logic [RW-1:0] rd);
      clr(); LongDoneValid = 1'b1; LongDoneRd = rd;
   endtask

   initial begin
      exp_sc = 4'd0;
      rst_n  = 1'b0;
      clr();
      @(posedge clk);
      #1;
      MemBusy = 1'b1; PCSrcE = 1'b1; RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3;
      chk("reset_outputs", NONE, 2'b00, 2'b00);
      rst_n = 1'b1;

      // Forwarding
      clr(); RegWriteM = 1'b1; RdM = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3;
      chk("fwd_mem_over_wb", NONE, 2'b10, 2'b00);
      clr(); RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
      chk("fwd_wb", NONE, 2'b01, 2'b01);
      clr(); RegWriteM = 1'b1; RegWriteW = 1'b1;
      chk("fwd_x0", NONE, 2'b00, 2'b00);
      clr(); RegWriteM = 1'b1; RdM = 5'd6; Rs1E = 5'd6; Rs2E = 5'd6; RdW = 5'd6;
      chk("fwd_mem_both", NONE, 2'b10, 2'b10);

      // Load-use, two bubbles
      clr(); ResultSrcE_b0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
      RdD = 5'd6; RegWriteD = 1'b1;
      chk("ld_use_c1", LDST, 2'b00, 2'b00);
      clr(); RegWriteM = 1'b1; RdM = 5'd5; Rs1D = 5'd5; RdD = 5'd6; RegWriteD = 1'b1;
      chk("ld_use_c2", LDST, 2'b00, 2'b00);
      clr(); Rs1E = 5'd5; RdE = 5'd6; RegWriteE = 1'b1; RegWriteW = 1'b1; RdW = 5'd5;
      chk("ld_use_release", NONE, 2'b01, 2'b00);

      // Scoreboard RAW on a single div
      long_op(5'd7); Rs1D = 5'd7;
      chk("div_issue", NONE, 2'b00, 2'b00);
      clr(); Rs1D = 5'd7;
      chk("sb_raw_c1", LDST, 2'b00, 2'b00);
      clr(); Rs1D = 5'd7;
      chk("sb_raw_c2", LDST, 2'b00, 2'b00);
      done(5'd7); Rs1D = 5'd7;
      chk("sb_raw_done_same_cycle", NONE, 2'b00, 2'b00);
      clr(); Rs1D = 5'd7;
      chk("sb_raw_cleared", NONE, 2'b00, 2'b00);

      // Long unit full
      for (int i = 10; i < 14; i++) begin
         long_op(RW'(i));
         chk("long_issue", NONE, 2'b00, 2'b00);
      end
      long_op(5'd14);
      chk("long_full_c1", FULL, 2'b00, 2'b00);
      long_op(5'd14);
      chk("long_full_c2", FULL, 2'b00, 2'b00);
      long_op(5'd14); LongDoneValid = 1'b1; LongDoneRd = 5'd10;
      chk("long_full_release", NONE, 2'b00, 2'b00);
      long_op(5'd15);
      chk("long_full_still_4", FULL, 2'b00, 2'b00);
      clr(); RegWriteD = 1'b1; RdD = 5'd12;
      chk("sb_waw", LDST, 2'b00, 2'b00);
      done(5'd12); RegWriteD = 1'b1; RdD = 5'd12;
      chk("sb_waw_done", NONE, 2'b00, 2'b00);
      done(5'd20);
      chk("done_not_pending", NONE, 2'b00, 2'b00);
      long_op(5'd16);
      chk("long_issue_4th", NONE, 2'b00, 2'b00);
      long_op(5'd17);
      chk("long_full_after_ignored_done", FULL, 2'b00, 2'b00);
      done(5'd11); chk("drain", NONE, 2'b00, 2'b00);
      done(5'd13); chk("drain", NONE, 2'b00, 2'b00);
      done(5'd14); chk("drain", NONE, 2'b00, 2'b00);
      done(5'd16); chk("drain", NONE, 2'b00, 2'b00);
      clr(); Rs1D = 5'd16; Rs2D = 5'd13;
      chk("drained_no_stall", NONE, 2'b00, 2'b00);

      // Branch overrides load-use
      clr(); ResultSrcE_b0 = 1'b1; RdE = 5'd5; RegWriteE = 1'b1; Rs1D = 5'd5; PCSrcE = 1'b1;
      chk("branch_over_ld_use", BRFL, 2'b00, 2'b00);
      clr();
      chk("branch_cleared_bubble", NONE, 2'b00, 2'b00);

      // Bubble counter freezes while busy
      clr(); ResultSrcE_b0 = 1'b1; RdE = 5'd5; RegWriteE = 1'b1; Rs2D = 5'd5;
      chk("ld_use_pre_busy", LDST, 2'b00, 2'b00);
      clr(); MemBusy = 1'b1;
      chk("busy_bubble_hold", BUSY, 2'b00, 2'b00);
      clr();
      chk("bubble_after_busy", LDST, 2'b00, 2'b00);
      clr();
      chk("bubble_done", NONE, 2'b00, 2'b00);

      // MemBusy with a pending div that completes mid-freeze
      long_op(5'd9);
      chk("div9_issue", NONE, 2'b00, 2'b00);
      clr(); Rs1D = 5'd9;
      chk("div9_raw", LDST, 2'b00, 2'b00);
      clr(); Rs1D = 5'd9; MemBusy = 1'b1; PCSrcE = 1'b1;
      chk("busy_c1", BUSY, 2'b00, 2'b00);
      done(5'd9); Rs1D = 5'd9; MemBusy = 1'b1;
      chk("busy_c2_done", BUSY, 2'b00, 2'b00);
      clr(); Rs1D = 5'd9; MemBusy = 1'b1;
      chk("busy_c3", BUSY, 2'b00, 2'b00);
      clr(); Rs1D = 5'd9;
      chk("busy_end_pend_cleared", NONE, 2'b00, 2'b00);

      // Asynchronous reset in mid-cycle drops pending state
      long_op(5'd9);
      chk("div9_reissue", NONE, 2'b00, 2'b00);
      clr(); Rs1D = 5'd9;
      chk("div9_raw_again", LDST, 2'b00, 2'b00);
      clr(); Rs1D = 5'd9;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      exp_sc = 4'd0;
      chk("async_rst_clears_pend", NONE, 2'b00, 2'b00);

      clr();
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: pending %0d want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
